// File: rtl/seq_gen_serial_if.sv
// rtl/seq_gen_serial_if.sv - Control/stream bundle between a pattern source and seq_gen_serial
interface seq_gen_serial_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, rep_cnt, gap,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, rep_cnt, gap,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_gen_serial.sv
// rtl/seq_gen_serial.sv - Repeating MSB-first serial pattern transmitter (optional parity: SEQ_GEN_PARITY_EN)
module seq_gen_serial #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_gen_serial_if.slave bus
);

  localparam int BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rep_end;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_q, par_d;
`endif

  // Next state plus the registered output values that belong to that next state.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    bit_d     = bit_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    par_d     = par_q;
    rep_end   = par_q;
`else
    rep_end   = (bit_q == '0);
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.rep_cnt != '0) begin
            state_d = SEND;
            pat_d   = bus.pattern;
            rep_d   = bus.rep_cnt;
            gap_d   = bus.gap;
            bit_d   = MSB_IDX;
            valid_d = 1'b1;
            out_d   = bus.pattern[PAT_W-1];
`ifdef SEQ_GEN_PARITY_EN
            par_d   = 1'b0;
`endif
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (rep_end) begin
          // Counter tested before decrement so a full-scale count never wraps.
          rep_d = rep_q - CNT_W'(1);
`ifdef SEQ_GEN_PARITY_EN
          par_d = 1'b0;
`endif
          if (rep_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            bit_d   = MSB_IDX;
            valid_d = 1'b1;
            out_d   = pat_q[PAT_W-1];
          end else begin
            state_d   = GAP;
            gap_cnt_d = gap_q;
          end
        end
`ifdef SEQ_GEN_PARITY_EN
        else if (bit_q == '0) begin
          par_d   = 1'b1;
          valid_d = 1'b1;
          out_d   = ^pat_q;
        end
`endif
        else begin
          bit_d   = bit_q - BIT_W'(1);
          valid_d = 1'b1;
          out_d   = pat_q[bit_d];
        end
      end

      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d = SEND;
          bit_d   = MSB_IDX;
          valid_d = 1'b1;
          out_d   = pat_q[PAT_W-1];
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SEND) || (state_d == GAP);
  end

  // State, captured parameters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_q     <= '0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      bit_q     <= bit_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
